// File: rtl/regfile_mp.sv
// Multi-read-port register file with sub-word merge/extend write-back,
// write-to-read forwarding and a per-register load-busy scoreboard.
module regfile_mp #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic                rd_valid,
  output logic                rd_stall,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [1:0]          wr_size,
  input  logic [1:0]          wr_ext,
  input  logic                busy_set,
  input  logic [AW-1:0]       busy_addr,
  output logic [NREG-1:0]     busy
);

  // Read handshake: rd_en has no ready; every edge with rd_en=1 captures all
  // ports and rd_valid=1 follows for exactly that cycle. rd_stall is advisory.

  logic [XLEN-1:0]     regs_q [NREG];
  logic [XLEN-1:0]     regs_d [NREG];
  logic [NRD*XLEN-1:0] rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic [NREG-1:0]     busy_q, busy_d;
  logic [XLEN-1:0]     wr_val;
  logic                wr_keep;
  logic [AW-1:0]       ra;
  logic                hit;

  function automatic logic [XLEN-1:0] merge_ext(
    input logic [XLEN-1:0] old_v,
    input logic [XLEN-1:0] wd,
    input logic [1:0]      sz,
    input logic [1:0]      ext
  );
    logic [XLEN-1:0] m;
    logic            sgn;
    logic [XLEN-1:0] r;
    m   = sz[0] ? XLEN'(16'hFFFF) : XLEN'(8'hFF);
    sgn = sz[0] ? wd[15] : wd[7];
    if (sz[1]) begin
      r = wd;
    end else begin
      case (ext)
        2'b00:   r = (old_v & ~m) | (wd & m);
        2'b01:   r = wd & m;
        default: r = (wd & m) | (sgn ? ~m : '0);
      endcase
    end
    return r;
  endfunction

  assign wr_val  = merge_ext(regs_q[wr_addr], wr_data, wr_size, wr_ext);
  assign wr_keep = wr_en && !((ZERO_R0 != 0) && (wr_addr == '0));

  always_comb begin
    regs_d = regs_q;
    if (wr_keep) regs_d[wr_addr] = wr_val;
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    rd_stall   = 1'b0;
    ra         = '0;
    hit        = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      ra  = rd_addr[i*AW +: AW];
      hit = wr_en && (wr_addr == ra);
      if (rd_en) begin
        if ((ZERO_R0 != 0) && (ra == '0))
          rd_data_d[i*XLEN +: XLEN] = '0;
        else if (hit)
          rd_data_d[i*XLEN +: XLEN] = wr_val;
        else
          rd_data_d[i*XLEN +: XLEN] = regs_q[ra];
      end
      // A write landing this edge resolves the pending load, so no stall.
      rd_stall = rd_stall | (busy_q[ra] && !hit);
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[wr_addr] = 1'b0;
    if (busy_set && !((ZERO_R0 != 0) && (busy_addr == '0)))
      busy_d[busy_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed cases plus randomized traffic against an
// arithmetic reference model; a second instance covers the 64-bit/3-port build.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance: XLEN=32, NREG=32, NRD=2
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        rd_valid, rd_stall;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  wr_size, wr_ext;
  logic        busy_set;
  logic [4:0]  busy_addr;
  logic [31:0] busy;

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_R0(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_stall(rd_stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_size(wr_size), .wr_ext(wr_ext), .busy_set(busy_set),
    .busy_addr(busy_addr), .busy(busy)
  );

  // Second instance: XLEN=64, NREG=16, NRD=3
  logic         p2_rd_en;
  logic [11:0]  p2_rd_addr;
  logic [191:0] p2_rd_data;
  logic         p2_rd_valid, p2_rd_stall;
  logic         p2_wr_en;
  logic [3:0]   p2_wr_addr;
  logic [63:0]  p2_wr_data;
  logic [1:0]   p2_wr_size, p2_wr_ext;
  logic         p2_busy_set;
  logic [3:0]   p2_busy_addr;
  logic [15:0]  p2_busy;

  regfile_mp #(.XLEN(64), .NREG(16), .NRD(3), .ZERO_R0(1)) dut_p2 (
    .clk(clk), .rst_n(rst_n), .rd_en(p2_rd_en), .rd_addr(p2_rd_addr),
    .rd_data(p2_rd_data), .rd_valid(p2_rd_valid), .rd_stall(p2_rd_stall),
    .wr_en(p2_wr_en), .wr_addr(p2_wr_addr), .wr_data(p2_wr_data),
    .wr_size(p2_wr_size), .wr_ext(p2_wr_ext), .busy_set(p2_busy_set),
    .busy_addr(p2_busy_addr), .busy(p2_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_reg [32];
  logic [31:0] m_busy;
  logic [31:0] m_rd [2];
  logic        m_valid;
  logic        obs_stall;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write value from the rules, using modular arithmetic on the payload width.
  function automatic logic [31:0] ref_wr(input logic [31:0] old_v, input logic [31:0] wd,
                                         input logic [1:0] sz, input logic [1:0] ext);
    logic [31:0] span, lo;
    if (sz >= 2'd2) return wd;
    span = (sz == 2'd0) ? 32'd256 : 32'd65536;
    lo   = wd % span;
    if (ext == 2'd0) return old_v - (old_v % span) + lo;
    if (ext == 2'd1) return lo;
    if (lo >= span / 2) return lo - span;
    return lo;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_busy  = '0;
    m_rd[0] = '0;
    m_rd[1] = '0;
    m_valid = 1'b0;
  endtask

  // One clock of traffic; entered just after a rising edge.
  task automatic do_cycle(input logic ren, input logic [4:0] a0, input logic [4:0] a1,
                          input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [1:0] ws, input logic [1:0] we,
                          input logic bs, input logic [4:0] ba);
    logic [31:0] nv;
    logic        es;
    rd_en = ren; rd_addr = {a1, a0};
    wr_en = wen; wr_addr = wa; wr_data = wd; wr_size = ws; wr_ext = we;
    busy_set = bs; busy_addr = ba;
    #2;
    es = (m_busy[a0] && !(wen && wa == a0)) || (m_busy[a1] && !(wen && wa == a1));
    obs_stall = rd_stall;
    check_eq("rd_stall", 64'(rd_stall), 64'(es));
    @(posedge clk);
    nv = ref_wr(m_reg[wa], wd, ws, we);
    if (ren) begin
      m_rd[0] = (a0 == 5'd0) ? 32'd0 : ((wen && wa == a0) ? nv : m_reg[a0]);
      m_rd[1] = (a1 == 5'd0) ? 32'd0 : ((wen && wa == a1) ? nv : m_reg[a1]);
    end
    m_valid = ren;
    if (wen && wa != 5'd0) m_reg[wa] = nv;
    if (wen) m_busy[wa] = 1'b0;
    if (bs && ba != 5'd0) m_busy[ba] = 1'b1;
    #1;
    check_eq("rd_data0", 64'(rd_data[31:0]), 64'(m_rd[0]));
    check_eq("rd_data1", 64'(rd_data[63:32]), 64'(m_rd[1]));
    check_eq("rd_valid", 64'(rd_valid), 64'(m_valid));
    check_eq("busy", 64'(busy), 64'(m_busy));
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [1:0] sz, input logic [1:0] ext);
    do_cycle(1'b0, 5'd0, 5'd0, 1'b1, a, d, sz, ext, 1'b0, 5'd0);
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    do_cycle(1'b1, a0, a1, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 1'b0, 5'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    rd_en = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    wr_size = '0; wr_ext = '0; busy_set = 1'b0; busy_addr = '0;
    p2_rd_en = 1'b0; p2_rd_addr = '0; p2_wr_en = 1'b0; p2_wr_addr = '0;
    p2_wr_data = '0; p2_wr_size = '0; p2_wr_ext = '0; p2_busy_set = 1'b0;
    p2_busy_addr = '0;
    model_reset();

    // Reset: rd_en held high must not raise rd_valid
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rd_data", rd_data, 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_valid", 64'(rd_valid), 64'd0);
    check_eq("rst_stall", 64'(rd_stall), 64'd0);
    rst_n = 1'b1;
    rd(5'd5, 5'd31);
    check_eq("post_rst_valid", 64'(rd_valid), 64'd1);
    check_eq("post_rst_r5", 64'(rd_data[31:0]), 64'd0);
    wr(5'd6, 32'h0, 2'd2, 2'd0);
    check_eq("valid_drops", 64'(rd_valid), 64'd0);

    // Sub-word write-back
    wr(5'd3, 32'hAABBCCDD, 2'd2, 2'd0);
    wr(5'd3, 32'h000000F0, 2'd0, 2'd0);
    rd(5'd3, 5'd0);
    check_eq("byte_merge", 64'(rd_data[31:0]), 64'hAABBCCF0);
    wr(5'd3, 32'hAABBCCDD, 2'd2, 2'd0);
    wr(5'd3, 32'h000000F0, 2'd0, 2'd2);
    rd(5'd3, 5'd0);
    check_eq("byte_sext", 64'(rd_data[31:0]), 64'hFFFFFFF0);
    wr(5'd3, 32'hAABBCCDD, 2'd2, 2'd0);
    wr(5'd3, 32'h00008001, 2'd1, 2'd1);
    rd(5'd3, 5'd0);
    check_eq("half_zext", 64'(rd_data[31:0]), 64'h00008001);
    wr(5'd3, 32'hAABBCCDD, 2'd2, 2'd0);
    wr(5'd3, 32'h00008001, 2'd1, 2'd3);
    rd(5'd3, 5'd0);
    check_eq("half_sext", 64'(rd_data[31:0]), 64'hFFFF8001);
    // Back-to-back merges build on each other
    wr(5'd3, 32'h11223344, 2'd2, 2'd0);
    wr(5'd3, 32'h000055AA, 2'd1, 2'd0);
    wr(5'd3, 32'h00000077, 2'd0, 2'd0);
    rd(5'd3, 5'd0);
    check_eq("waw_merge", 64'(rd_data[31:0]), 64'h11225577);

    // Forwarding, and r0 ignores writes
    do_cycle(1'b1, 5'd7, 5'd0, 1'b1, 5'd7, 32'h12345678, 2'd2, 2'd0, 1'b0, 5'd0);
    check_eq("fwd_r7", 64'(rd_data[31:0]), 64'h12345678);
    check_eq("fwd_r0", 64'(rd_data[63:32]), 64'd0);
    do_cycle(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 32'hDEADBEEF, 2'd2, 2'd0, 1'b0, 5'd0);
    rd(5'd0, 5'd7);
    check_eq("r0_zero", 64'(rd_data[31:0]), 64'd0);

    // Scoreboard
    do_cycle(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 1'b1, 5'd9);
    check_eq("busy9_set", 64'(busy[9]), 64'd1);
    rd(5'd9, 5'd0);
    check_eq("stall_r9", 64'(obs_stall), 64'd1);
    do_cycle(1'b1, 5'd0, 5'd9, 1'b1, 5'd9, 32'hCAFEF00D, 2'd2, 2'd0, 1'b0, 5'd0);
    check_eq("stall_r9_wr", 64'(obs_stall), 64'd0);
    check_eq("fwd_r9", 64'(rd_data[63:32]), 64'hCAFEF00D);
    check_eq("busy9_clr", 64'(busy[9]), 64'd0);
    do_cycle(1'b0, 5'd0, 5'd0, 1'b1, 5'd4, 32'h55, 2'd2, 2'd0, 1'b1, 5'd4);
    check_eq("busy4_collide", 64'(busy[4]), 64'd1);
    do_cycle(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 1'b1, 5'd0);
    check_eq("busy0_never", 64'(busy[0]), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      do_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom,
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)));
    end

    // Asynchronous reset mid-cycle
    do_cycle(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 32'h0BADF00D, 2'd2, 2'd0, 1'b1, 5'd12);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_data", rd_data, 64'd0);
    check_eq("async_rst_busy", 64'(busy), 64'd0);
    check_eq("async_rst_valid", 64'(rd_valid), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd(5'd7, 5'd3);

    // 64-bit, 3-port, 16-register build
    p2_rd_en = 1'b1; p2_rd_addr = {4'd15, 4'd15, 4'd15};
    p2_wr_en = 1'b1; p2_wr_addr = 4'd15; p2_wr_data = 64'h8000;
    p2_wr_size = 2'd1; p2_wr_ext = 2'd2;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      check_eq("p2_fwd", p2_rd_data[i*64 +: 64], 64'hFFFFFFFFFFFF8000);
    check_eq("p2_valid", 64'(p2_rd_valid), 64'd1);
    p2_wr_en = 1'b0;
    p2_rd_addr = {4'd0, 4'd15, 4'd15};
    @(posedge clk);
    #1;
    check_eq("p2_stored", p2_rd_data[64 +: 64], 64'hFFFFFFFFFFFF8000);
    check_eq("p2_r0", p2_rd_data[128 +: 64], 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
